// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use interlock, mul/div and bus holds,
// and IF/ID flushing after taken jumps. Drives stall/flush controls to PC, IF_ID and ID_EX.
module pipe_hazard_ctrl #(
    parameter int RADDR_W    = 5,
    parameter int FLUSH_CYC  = 2,
    parameter int MD_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_reg1_re_i,
    input  logic [RADDR_W-1:0] id_reg1_raddr_i,
    input  logic               id_reg2_re_i,
    input  logic [RADDR_W-1:0] id_reg2_raddr_i,
    input  logic               ex_load_i,
    input  logic               ex_reg_we_i,
    input  logic [RADDR_W-1:0] ex_reg_waddr_i,
    input  logic               ex_md_start_i,
    input  logic               md_done_i,
    input  logic               ex_jump_i,
    input  logic               bus_hold_i,
    output logic               stall_pc_o,
    output logic               stall_ifid_o,
    output logic               stall_idex_o,
    output logic               flush_ifid_o,
    output logic               bubble_idex_o,
    output logic               md_timeout_o,
    output logic [1:0]         state_o
);

    localparam int MD_CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);
    localparam logic [MD_CNT_W-1:0] MD_MAX  = '1;
    localparam logic [1:0]          FL_LOAD = 2'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_WAIT = 2'd1,
        S_FLUSH   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          flush_cnt, flush_cnt_nxt;
    logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;

    logic lu_hazard;
    logic md_expired;
    logic stall_pc, stall_ifid, stall_idex, flush_ifid, bubble_idex, md_timeout;

    // x0 is hardwired zero, so a load targeting it can never feed a stale value.
    always_comb begin
        lu_hazard = ex_load_i && ex_reg_we_i && (ex_reg_waddr_i != '0) &&
                    ((id_reg1_re_i && (id_reg1_raddr_i == ex_reg_waddr_i)) ||
                     (id_reg2_re_i && (id_reg2_raddr_i == ex_reg_waddr_i)));
    end

    assign md_expired = (md_cnt == MD_LAST) && !md_done_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            flush_cnt <= '0;
            md_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            md_cnt    <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        md_cnt_nxt    = md_cnt;
        unique case (state)
            S_RUN: begin
                if (ex_jump_i) begin
                    if (FLUSH_CYC > 1) begin
                        state_nxt     = S_FLUSH;
                        flush_cnt_nxt = FL_LOAD;
                    end
                end else if (ex_md_start_i) begin
                    state_nxt  = S_MD_WAIT;
                    md_cnt_nxt = '0;
                end else if (bus_hold_i) begin
                    state_nxt = S_HOLD;
                end
            end
            S_MD_WAIT: begin
                if (md_cnt != MD_MAX) begin
                    md_cnt_nxt = md_cnt + MD_CNT_W'(1);
                end
                if (md_done_i || md_expired) begin
                    state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                flush_cnt_nxt = flush_cnt - 2'd1;
                if (flush_cnt <= 2'd1) begin
                    state_nxt     = S_RUN;
                    flush_cnt_nxt = '0;
                end
            end
            S_HOLD: begin
                if (!bus_hold_i) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        md_timeout  = 1'b0;
        unique case (state)
            S_RUN: begin
                if (ex_jump_i) begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else if (ex_md_start_i || bus_hold_i) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                end else if (lu_hazard) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            S_MD_WAIT: begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                stall_idex = 1'b1;
                md_timeout = md_expired;
            end
            S_FLUSH: begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end
            S_HOLD: begin
                if (bus_hold_i) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                end else if (lu_hazard) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are forced low while rst is high so nothing leaks through before the first edge.
    always_comb begin
        stall_pc_o    = stall_pc && !rst;
        stall_ifid_o  = stall_ifid && !flush_ifid && !rst;
        stall_idex_o  = stall_idex && !bubble_idex && !rst;
        flush_ifid_o  = flush_ifid && !rst;
        bubble_idex_o = bubble_idex && !rst;
        md_timeout_o  = md_timeout && !rst;
        state_o       = state;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl: a behavioural sequencer model pushes the expected
// output vector each cycle; an independent monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int RADDR_W    = 5;
    localparam int FLUSH_CYC  = 2;
    localparam int MD_TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               id_reg1_re_i = 1'b0, id_reg2_re_i = 1'b0;
    logic [RADDR_W-1:0] id_reg1_raddr_i = '0, id_reg2_raddr_i = '0, ex_reg_waddr_i = '0;
    logic               ex_load_i = 1'b0, ex_reg_we_i = 1'b0, ex_md_start_i = 1'b0;
    logic               md_done_i = 1'b0, ex_jump_i = 1'b0, bus_hold_i = 1'b0;
    logic               stall_pc_o, stall_ifid_o, stall_idex_o, flush_ifid_o;
    logic               bubble_idex_o, md_timeout_o;
    logic [1:0]         state_o;

    pipe_hazard_ctrl #(
        .RADDR_W(RADDR_W), .FLUSH_CYC(FLUSH_CYC), .MD_TIMEOUT(MD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .id_reg1_re_i(id_reg1_re_i), .id_reg1_raddr_i(id_reg1_raddr_i),
        .id_reg2_re_i(id_reg2_re_i), .id_reg2_raddr_i(id_reg2_raddr_i),
        .ex_load_i(ex_load_i), .ex_reg_we_i(ex_reg_we_i), .ex_reg_waddr_i(ex_reg_waddr_i),
        .ex_md_start_i(ex_md_start_i), .md_done_i(md_done_i), .ex_jump_i(ex_jump_i),
        .bus_hold_i(bus_hold_i),
        .stall_pc_o(stall_pc_o), .stall_ifid_o(stall_ifid_o), .stall_idex_o(stall_idex_o),
        .flush_ifid_o(flush_ifid_o), .bubble_idex_o(bubble_idex_o),
        .md_timeout_o(md_timeout_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, jmp, mds, mdd, bh, ld, we;
        logic [4:0] wa;
        logic       re1;
        logic [4:0] a1;
        logic       re2;
        logic [4:0] a2;
    } stim_t;

    // {state[1:0], timeout, bubble_idex, flush_ifid, stall_idex, stall_ifid, stall_pc}
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    // Model state: what the pipeline is currently waiting on.
    bit m_in_md      = 0;
    int m_md_waited  = 0;
    int m_flush_left = 0;
    bit m_holding    = 0;

    task automatic drive(input stim_t s);
        bit         hz;
        logic       spc, sif, sid, fl, bub, to;
        logic [1:0] st;
        @(posedge clk);
        #1;
        rst = s.rst; ex_jump_i = s.jmp; ex_md_start_i = s.mds; md_done_i = s.mdd;
        bus_hold_i = s.bh; ex_load_i = s.ld; ex_reg_we_i = s.we; ex_reg_waddr_i = s.wa;
        id_reg1_re_i = s.re1; id_reg1_raddr_i = s.a1; id_reg2_re_i = s.re2; id_reg2_raddr_i = s.a2;
        hz = s.ld && s.we && (s.wa != 0) && ((s.re1 && s.a1 == s.wa) || (s.re2 && s.a2 == s.wa));
        {spc, sif, sid, fl, bub, to} = '0;
        st = 2'd0;
        if (s.rst) begin
            m_in_md = 0; m_md_waited = 0; m_flush_left = 0; m_holding = 0;
        end else if (m_in_md) begin
            st = 2'd1;
            {spc, sif, sid} = 3'b111;
            if (s.mdd) m_in_md = 0;
            else if (m_md_waited == MD_TIMEOUT - 1) begin to = 1; m_in_md = 0; end
            else m_md_waited++;
        end else if (m_flush_left > 0) begin
            st = 2'd2;
            {fl, bub} = 2'b11;
            m_flush_left--;
        end else if (m_holding) begin
            st = 2'd3;
            if (s.bh) {spc, sif, sid} = 3'b111;
            else begin
                m_holding = 0;
                if (hz) {spc, sif, bub} = 3'b111;
            end
        end else if (s.jmp) begin
            {fl, bub} = 2'b11;
            m_flush_left = FLUSH_CYC - 1;
        end else if (s.mds) begin
            {spc, sif, sid} = 3'b111;
            m_in_md = 1; m_md_waited = 0;
        end else if (s.bh) begin
            {spc, sif, sid} = 3'b111;
            m_holding = 1;
        end else if (hz) begin
            {spc, sif, bub} = 3'b111;
        end
        exp_q.push_back({st, to, bub, fl, sid, sif, spc});
    endtask

    always @(negedge clk) begin
        logic [7:0] act, e;
        cyc++;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {state_o, md_timeout_o, bubble_idex_o, flush_ifid_o,
                   stall_idex_o, stall_ifid_o, stall_pc_o};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d {st,to,bub,fl,sid,sif,spc} got=%b want=%b",
                         cyc, act, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bit    bh_state;
        int    done_div;

        s = '0; s.rst = 1;
        drive(s); drive(s);

        // Load-use on rs1, then the hazard clears.
        s = '0; s.ld = 1; s.we = 1; s.wa = 5; s.re1 = 1; s.a1 = 5;
        drive(s);
        s = '0; drive(s);
        // Load to x0 read as x0; load to x5 with rs1 not read.
        s = '0; s.ld = 1; s.we = 1; s.wa = 0; s.re1 = 1; s.a1 = 0; s.re2 = 1; s.a2 = 0;
        drive(s);
        s = '0; s.ld = 1; s.we = 1; s.wa = 5; s.re1 = 0; s.a1 = 5;
        drive(s);
        // Mul/div finishing 10 cycles after start.
        s = '0; s.mds = 1; drive(s);
        s = '0; for (int i = 0; i < 9; i++) drive(s);
        s.mdd = 1; drive(s);
        s = '0; drive(s);
        // Mul/div that never finishes.
        s = '0; s.mds = 1; drive(s);
        s = '0; for (int i = 0; i < 70; i++) drive(s);
        // Jump with a simultaneous load-use hazard.
        s = '0; s.jmp = 1; s.ld = 1; s.we = 1; s.wa = 7; s.re2 = 1; s.a2 = 7;
        drive(s);
        s.jmp = 0; drive(s);
        s = '0; drive(s);
        // Bus hold, released while a load-use hazard is present.
        s = '0; s.bh = 1; drive(s); drive(s); drive(s);
        s = '0; s.ld = 1; s.we = 1; s.wa = 3; s.re1 = 1; s.a1 = 3; drive(s);
        s = '0; drive(s);
        // Reset in the middle of a mul/div wait.
        s = '0; s.mds = 1; drive(s);
        s = '0; for (int i = 0; i < 5; i++) drive(s);
        s.rst = 1; s.bh = 1; drive(s); drive(s);
        s = '0; drive(s);

        bh_state = 0;
        for (int n = 0; n < 3000; n++) begin
            done_div = (n < 1500) ? 11 : 150;
            s = '0;
            s.rst = ($urandom_range(0, 399) == 0);
            s.jmp = ($urandom_range(0, 9) == 0);
            s.mds = ($urandom_range(0, 11) == 0);
            s.mdd = ($urandom_range(0, done_div) == 0);
            if ($urandom_range(0, 5) == 0) bh_state = ~bh_state;
            s.bh  = bh_state;
            s.ld  = 1'($urandom_range(0, 1));
            s.we  = 1'($urandom_range(0, 3) != 0);
            s.wa  = 5'($urandom_range(0, 3));
            s.re1 = 1'($urandom_range(0, 1));
            s.a1  = 5'($urandom_range(0, 3));
            s.re2 = 1'($urandom_range(0, 1));
            s.a2  = 5'($urandom_range(0, 3));
            drive(s);
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
